rf_writeback_arbiter: RTL

Owns the single register-file write port (write, Daddress, Ddata) and arbitrates it between single-cycle ALU results and in-order, variable-latency load responses from data memory. Tracks outstanding loads in a small FIFO, aligns and sign- or zero-extends returned words, and exports a pending-destination mask for the issue stage's hazard stall. Sits between execute/memory and the register file in the core.

---
 rtl/rf_writeback_arbiter_pkg.sv | 24 ++
 rtl/rf_load_align.sv | 43 ++++
 rtl/rf_writeback_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared core definitions for the register-file writeback path.
// Contents:
//   XLEN, REG_AW, NUM_REGS : datapath width, register address width, register count
//   F3_*                   : load funct3 encodings understood by the aligner
//   ld_entry_t             : one outstanding-load record {rd, funct3, offset}
package rf_writeback_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        offset;
  } ld_entry_t;

endpackage

// File: rtl/rf_load_align.sv
// Load data aligner: selects the addressed byte/halfword from a raw 32-bit memory word and
// sign- or zero-extends it according to the load funct3. Purely combinational.
// Ports:
//   i_funct3 : load type (LB/LH/LW/LBU/LHU; other codes pass the full word)
//   i_offset : byte address bits [1:0] (bit 0 ignored for halfwords)
//   i_word   : raw aligned 32-bit word from memory
//   o_result : formatted 32-bit register value
module rf_load_align
  import rf_writeback_arbiter_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_result = {24'h000000, w_byte};
      F3_LHU:  o_result = {16'h0000, w_half};
      default: o_result = i_word;  // LW and unused codes
    endcase
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write port arbiter. ALU results have absolute priority; in-order load
// responses are formatted into a one-entry hold register and drained on the first cycle the
// ALU leaves the port free. Outstanding loads are tracked in a DEPTH-entry FIFO, and a
// pending-destination mask is exported for the issue-stage hazard stall.
// Ports:
//   clk, rst                          : clock (rising edge), async active-low reset
//   alu_valid/alu_rd/alu_data         : single-cycle ALU writeback request
//   ld_issue_valid/_ready/_rd/_funct3/_offset : load issue handshake and descriptor
//   mem_rsp_valid/_ready/_data        : in-order load response handshake and raw word
//   write/Daddress/Ddata              : register-file write port (combinational)
//   pending                           : bit N set while a load to xN is outstanding
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                ld_issue_valid,
  output logic                ld_issue_ready,
  input  logic [REG_AW-1:0]   ld_issue_rd,
  input  logic [2:0]          ld_issue_funct3,
  input  logic [1:0]          ld_issue_offset,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [XLEN-1:0]     mem_rsp_data,
  output logic                write,
  output logic [REG_AW-1:0]   Daddress,
  output logic [XLEN-1:0]     Ddata,
  output logic [NUM_REGS-1:0] pending
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ld_entry_t             r_fifo [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_hold_valid;
  logic [REG_AW-1:0]     r_hold_rd;
  logic [XLEN-1:0]       r_hold_data;
  logic [NUM_REGS-1:0]   r_pending;

  logic                  w_issue_fire;
  logic                  w_rsp_fire;
  logic                  w_drain;
  ld_entry_t             w_head;
  logic [XLEN-1:0]       w_aligned;
  logic [NUM_REGS-1:0]   w_pending_d;
  logic [CNT_W-1:0]      w_count_d;

  // Ready depends only on registered state, so a pop in the same cycle cannot free a slot.
  assign ld_issue_ready = (r_count < DEPTH_C) &&
                          !(r_pending[ld_issue_rd] && (ld_issue_rd != '0));
  // A new response may only land when the hold register will be free after this edge.
  assign mem_rsp_ready  = (r_count != '0) && (!r_hold_valid || !alu_valid);

  assign w_issue_fire = ld_issue_valid && ld_issue_ready;
  assign w_rsp_fire   = mem_rsp_valid && mem_rsp_ready;
  assign w_drain      = r_hold_valid && !alu_valid;
  assign w_head       = r_fifo[r_rptr];
  assign pending      = r_pending;

  rf_load_align u_align (
    .i_funct3 (w_head.funct3),
    .i_offset (w_head.offset),
    .i_word   (mem_rsp_data),
    .o_result (w_aligned)
  );

  // Write port; gated by rst so nothing reaches the register file during reset.
  always_comb begin
    write    = 1'b0;
    Daddress = '0;
    Ddata    = '0;
    if (rst) begin
      if (alu_valid) begin
        write    = 1'b1;
        Daddress = alu_rd;
        Ddata    = alu_data;
      end else if (r_hold_valid) begin
        write    = (r_hold_rd != '0);
        Daddress = r_hold_rd;
        Ddata    = r_hold_data;
      end
    end
  end

  // An issued rd can never equal the draining hold_rd (issue is blocked while pending),
  // but letting the set win keeps the mask safe regardless.
  always_comb begin
    w_pending_d = r_pending;
    if (w_drain) begin
      w_pending_d[r_hold_rd] = 1'b0;
    end
    if (w_issue_fire && (ld_issue_rd != '0)) begin
      w_pending_d[ld_issue_rd] = 1'b1;
    end
  end

  assign w_count_d = r_count + CNT_W'(w_issue_fire) - CNT_W'(w_rsp_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_hold_valid <= 1'b0;
      r_hold_rd    <= '0;
      r_hold_data  <= '0;
      r_pending    <= '0;
    end else begin
      r_count   <= w_count_d;
      r_pending <= w_pending_d;
      if (w_issue_fire) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rsp_fire) begin
        r_rptr       <= r_rptr + PTR_W'(1);
        r_hold_valid <= 1'b1;
        r_hold_rd    <= w_head.rd;
        r_hold_data  <= w_aligned;
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_issue_fire) begin
      r_fifo[r_wptr] <= '{rd: ld_issue_rd, funct3: ld_issue_funct3, offset: ld_issue_offset};
    end
  end

endmodule
